// File: rtl/clock_pkg.sv
// Shared types and board timing constants for the digital clock's button path.
// All cycle counts assume the DE10-Lite 50 MHz oscillator.
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHORT = 2'd1,
        HELD  = 2'd2
    } press_state_t;

    localparam int CLK_HZ = 50_000_000;

    function automatic int ms_to_cycles(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

    localparam int DEBOUNCE_20MS = ms_to_cycles(20);
    localparam int LONG_0P5S     = ms_to_cycles(500);
    localparam int REPEAT_0P2S   = ms_to_cycles(200);

endpackage

// File: rtl/btn_sync_debounce.sv
// Two-flop synchroniser, polarity normalisation and stability counter that
// turns a bouncing KEY pin into a clean registered `pressed` level.
module btn_sync_debounce
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
    parameter int CNT_W           = 26,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic button_raw,
    output logic pressed
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             btn;
    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] cnt_db;

    // After this xor a 1 always means "pressed", whatever the board wiring.
    assign btn = button_raw ^ ACTIVE_LOW;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= btn;
            sync_2 <= sync_1;
        end
    end

    // Any cycle that agrees with the accepted level restarts the stability run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pressed <= 1'b0;
            cnt_db  <= '0;
        end else if (sync_2 == pressed) begin
            cnt_db <= '0;
        end else if (cnt_db == DB_LAST) begin
            pressed <= ~pressed;
            cnt_db  <= '0;
        end else begin
            cnt_db <= cnt_db + CNT_W'(1);
        end
    end

endmodule

// File: rtl/button_event_gen.sv
// Turns one debounced push-button into single-cycle short, long and
// auto-repeat events for the clock's time-setting logic.
module button_event_gen
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
    parameter int LONG_CYCLES     = LONG_0P5S,
    parameter int REPEAT_CYCLES   = REPEAT_0P2S,
    parameter int CNT_W           = 26,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic button_raw,
    output logic pressed,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    // cnt_hold is cleared on the edge that enters SHORT, so firing on the edge
    // where it would step to LONG_CYCLES-1 puts long_pulse exactly
    // LONG_CYCLES cycles after pressed rose.
    localparam logic [CNT_W-1:0] HOLD_FIRE = CNT_W'(LONG_CYCLES - 2);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    press_state_t     state;
    logic             pressed_q;
    logic [CNT_W-1:0] cnt_hold;
    logic [CNT_W-1:0] cnt_rep;

    btn_sync_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_debounce (
        .clk        (clk),
        .reset_n    (reset_n),
        .button_raw (button_raw),
        .pressed    (pressed)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            pressed_q    <= 1'b0;
            cnt_hold     <= '0;
            cnt_rep      <= '0;
            short_pulse  <= 1'b0;
            long_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
        end else begin
            pressed_q    <= pressed;
            short_pulse  <= 1'b0;
            long_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (pressed && !pressed_q) begin
                        state    <= SHORT;
                        cnt_hold <= '0;
                    end
                end
                SHORT: begin
                    // Release is checked first so it wins over a coincident long threshold.
                    if (!pressed) begin
                        short_pulse <= 1'b1;
                        state       <= IDLE;
                        cnt_hold    <= '0;
                    end else if (cnt_hold == HOLD_FIRE) begin
                        long_pulse <= 1'b1;
                        state      <= HELD;
                        cnt_hold   <= '0;
                        cnt_rep    <= '0;
                    end else begin
                        cnt_hold <= cnt_hold + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!pressed) begin
                        state   <= IDLE;
                        cnt_rep <= '0;
                    end else if (cnt_rep == REP_LAST) begin
                        repeat_pulse <= 1'b1;
                        cnt_rep      <= '0;
                    end else begin
                        cnt_rep <= cnt_rep + CNT_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    cnt_hold <= '0;
                    cnt_rep  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_event_gen.sv
// Bench for button_event_gen: directed scenarios plus random button activity,
// checked by a window-based debounce model and a press-duration event model.
module tb_button_event_gen;

    localparam int DB    = 4;
    localparam int L_CYC = 20;
    localparam int R_CYC = 8;
    localparam int W     = 34;

    logic clk;
    logic reset_n;
    logic button_raw;
    logic pressed;
    logic short_pulse;
    logic long_pulse;
    logic repeat_pulse;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // {cycle[31:0], type[1:0]} with type 1 = short, 2 = long, 3 = repeat
    logic [W-1:0] exp_q[$];

    bit   hist[$];
    logic pressed_m;
    logic prev_m;
    logic all_diff;
    int   rise_cyc;

    int n_short = 0;
    int n_long  = 0;
    int n_rep   = 0;
    int s0, l0, r0;

    logic [2:0]   got;
    logic [W-1:0] ev;

    button_event_gen #(
        .DEBOUNCE_CYCLES (DB),
        .LONG_CYCLES     (L_CYC),
        .REPEAT_CYCLES   (R_CYC),
        .CNT_W           (8),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .button_raw   (button_raw),
        .pressed      (pressed),
        .short_pulse  (short_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL timeout: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- reference model ----------------
    // pressed flips once the last DB synchronised samples all disagree with it;
    // events follow from rise/fall times of pressed with plain arithmetic.
    always @(posedge clk) begin
        cyc++;
        if (!reset_n) begin
            hist.delete();
            for (int i = 0; i < DB + 2; i++) hist.push_back(1'b0);
            pressed_m = 1'b0;
            rise_cyc  = 0;
            exp_q.delete();
        end else begin
            hist.push_back(~button_raw);
            if (hist.size() > DB + 2) void'(hist.pop_front());
            prev_m   = pressed_m;
            all_diff = 1'b1;
            for (int i = 0; i < DB; i++) if (hist[i] == prev_m) all_diff = 1'b0;
            if (all_diff) pressed_m = ~prev_m;
            if (prev_m) begin
                if (cyc == rise_cyc + L_CYC)
                    exp_q.push_back({32'(cyc), 2'd2});
                else if (cyc > rise_cyc + L_CYC && ((cyc - rise_cyc - L_CYC) % R_CYC) == 0)
                    exp_q.push_back({32'(cyc), 2'd3});
            end
            if (!prev_m && pressed_m) rise_cyc = cyc;
            if (prev_m && !pressed_m && (cyc - rise_cyc) < L_CYC)
                exp_q.push_back({32'(cyc + 1), 2'd1});
        end
    end

    // ---------------- monitor / scoreboard ----------------
    function automatic logic [1:0] ev_code(input logic [2:0] g);
        if (g[0]) return 2'd1;
        if (g[1]) return 2'd2;
        return 2'd3;
    endfunction

    always @(negedge clk) begin
        if (reset_n) begin
            checks++;
            if (pressed !== pressed_m) begin
                failures++;
                $display("FAIL pressed_level: cycle=%0d got=%b required=%b", cyc, pressed, pressed_m);
            end
            got = {repeat_pulse, long_pulse, short_pulse};
            if (got != 3'b000) begin
                if (short_pulse)  n_short++;
                if (long_pulse)   n_long++;
                if (repeat_pulse) n_rep++;
                checks++;
                if ($countones(got) != 1) begin
                    failures++;
                    $display("FAIL exclusive: cycle=%0d pulses={rep,long,short}=%b required one-hot", cyc, got);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event: cycle=%0d type=%0d required no event", cyc, ev_code(got));
                end else begin
                    ev = exp_q.pop_front();
                    if (ev != {32'(cyc), ev_code(got)}) begin
                        failures++;
                        $display("FAIL event: got cycle=%0d type=%0d required cycle=%0d type=%0d",
                                 cyc, ev_code(got), ev[W-1:2], ev[1:0]);
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0][W-1:2] <= 32'(cyc)) begin
                checks++;
                failures++;
                ev = exp_q.pop_front();
                $display("FAIL missed_event: cycle=%0d got none required type=%0d at cycle=%0d",
                         cyc, ev[1:0], ev[W-1:2]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks are entered at a falling edge and return at a falling edge.
    task automatic set_raw(input logic v);
        #1 button_raw = v;
    endtask

    task automatic drive(input logic v, input int n);
        set_raw(v);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({pressed, short_pulse, long_pulse, repeat_pulse} !== 4'b0000) begin
            failures++;
            $display("FAIL %s: outputs={pressed,short,long,rep}=%b required 0000", name,
                     {pressed, short_pulse, long_pulse, repeat_pulse});
        end
    endtask

    task automatic apply_reset(input int n, input logic raw_during);
        #1 reset_n = 1'b0;
        #1 check_zero("reset_immediate");
        button_raw = raw_during;
        repeat (n) @(negedge clk);
        check_zero("reset_held");
        #1 reset_n = 1'b1;
        @(negedge clk);
    endtask

    function automatic logic sel(input int which);
        case (which)
            0:       return pressed;
            1:       return short_pulse;
            2:       return long_pulse;
            default: return repeat_pulse;
        endcase
    endfunction

    task automatic wait_for(input string name, input int which, input int exp_lat, input int budget);
        int lat;
        lat = 0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (sel(which)) begin
                lat = k;
                break;
            end
        end
        checks++;
        if (lat != exp_lat) begin
            failures++;
            $display("FAIL %s: latency=%0d required=%0d (0 means not seen in %0d cycles)",
                     name, lat, exp_lat, budget);
        end
    endtask

    task automatic snap();
        s0 = n_short;
        l0 = n_long;
        r0 = n_rep;
    endtask

    task automatic expect_counts(input string name, input int es, input int el, input int er);
        checks++;
        if (n_short - s0 != es || n_long - l0 != el || n_rep - r0 != er) begin
            failures++;
            $display("FAIL %s: short/long/rep=%0d/%0d/%0d required %0d/%0d/%0d", name,
                     n_short - s0, n_long - l0, n_rep - r0, es, el, er);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n    = 1'b0;
        button_raw = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_zero("reset_state");
            @(negedge clk);
        end
        // Button held through reset: seen as a fresh press after debounce.
        snap();
        #1 reset_n = 1'b1;
        wait_for("press_after_reset", 0, 2 + DB, 20);
        drive(1'b1, 20);
        expect_counts("press_after_reset_short", 1, 0, 0);

        // Short press and its release latency.
        snap();
        drive(1'b0, 12);
        set_raw(1'b1);
        wait_for("short_latency", 1, 3 + DB, 20);
        drive(1'b1, 10);
        expect_counts("short_press", 1, 0, 0);

        // Bounce shorter than the debounce window.
        snap();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, DB - 1);
            checks++;
            if (pressed !== 1'b0) begin
                failures++;
                $display("FAIL bounce_pressed: got=%b required=0", pressed);
            end
            drive(1'b1, 1);
        end
        drive(1'b1, 10);
        expect_counts("bounce", 0, 0, 0);

        // Long press with auto-repeat, held 60 cycles.
        snap();
        set_raw(1'b0);
        wait_for("long_press_rise", 0, 2 + DB, 20);
        wait_for("long_latency", 2, L_CYC, 40);
        wait_for("repeat_first", 3, R_CYC, 20);
        wait_for("repeat_second", 3, R_CYC, 20);
        repeat (60 - (2 + DB) - L_CYC - 2 * R_CYC) @(negedge clk);
        drive(1'b1, 15);
        expect_counts("long_repeat", 0, 1, 5);

        // pressed falls on the cycle the long threshold would fire: short only.
        snap();
        drive(1'b0, L_CYC - 1);
        drive(1'b1, 15);
        expect_counts("boundary_short", 1, 0, 0);

        // One cycle longer: long fires and the release gives nothing.
        snap();
        drive(1'b0, L_CYC);
        drive(1'b1, 15);
        expect_counts("boundary_long", 0, 1, 0);

        // Reset between repeat pulses while held.
        snap();
        set_raw(1'b0);
        repeat (2 + DB + L_CYC + R_CYC + 4) @(negedge clk);
        apply_reset(3, 1'b1);
        drive(1'b1, 25);
        expect_counts("reset_mid_held", 0, 1, 1);
        checks++;
        if (pressed !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_held_pressed: got=%b required=0", pressed);
        end

        // Random button activity with occasional resets.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 19) == 0)
                apply_reset($urandom_range(1, 3), 1'($urandom_range(0, 1)));
            else
                drive(1'($urandom_range(0, 1)), $urandom_range(1, 40));
        end
        drive(1'b1, 40);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL leftover_events: got %0d pending required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_event_gen.md
# button_event_gen

Converts one raw DE10-Lite push-button into clean, single-cycle press events for the time-setting logic of the digital clock. It synchronises and debounces the input, then classifies each press as short or long. While a long press is held, it emits periodic auto-repeat events. One instance sits between each board KEY pin and the clock core, which consumes only one-cycle pulses.

## Interface
- DEBOUNCE_CYCLES, 1_000_000 — consecutive stable cycles required to accept a level change (20 ms at 50 MHz); ≥ 2
- LONG_CYCLES, 25_000_000 — debounced-press duration that makes a press long (0.5 s); > DEBOUNCE_CYCLES
- REPEAT_CYCLES, 10_000_000 — auto-repeat period while held after the long threshold (0.2 s); ≥ 2
- CNT_W, 26 — counter width; must hold max(LONG_CYCLES, REPEAT_CYCLES, DEBOUNCE_CYCLES) − 1
- ACTIVE_LOW, 1 — 1: button_raw is 0 when pressed (DE10 KEY); 0: 1 when pressed
- clk  input  1  system clock, 50 MHz
- reset_n  input  1  asynchronous, active-low reset
- button_raw  input  1  raw asynchronous button pin
- pressed  output  1  debounced level, 1 = pressed
- short_pulse  output  1  one-cycle pulse on release of a short press
- long_pulse  output  1  one-cycle pulse when the long threshold is reached
- repeat_pulse  output  1  one-cycle pulse every REPEAT_CYCLES while held past the long threshold

## Operation
- Polarity: `btn = button_raw ^ ACTIVE_LOW`, so 1 always means pressed.
- Synchroniser: two flops; both reset to 0 (released).
- Debounce: cnt_db counts cycles where the synchronised value ≠ pressed.
  - cnt_db clears on any cycle where they are equal.
  - When cnt_db == DEBOUNCE_CYCLES−1 and the values still differ, `pressed` toggles and cnt_db clears.
- Press FSM, states IDLE, SHORT, HELD; cnt_hold and cnt_rep are CNT_W-bit counters.
  - IDLE: on the rising edge of `pressed`, go to SHORT and set cnt_hold = 0.
  - SHORT, `pressed` = 1: cnt_hold increments. At cnt_hold == LONG_CYCLES−1, assert long_pulse, go to HELD, set cnt_rep = 0.
  - SHORT, `pressed` = 0: assert short_pulse and go to IDLE.
  - HELD, `pressed` = 1: cnt_rep increments. At cnt_rep == REPEAT_CYCLES−1, assert repeat_pulse and set cnt_rep = 0.
  - HELD, `pressed` = 0: go to IDLE with no pulse.
- Simultaneous events: a release in the same cycle the long threshold would fire takes priority. The block gives short_pulse only, never long_pulse.
- Mutual exclusion: at most one of short/long/repeat is high in any cycle. Each press yields exactly one short_pulse or exactly one long_pulse, never both.
- Glitches: any glitch shorter than DEBOUNCE_CYCLES has no effect on outputs.
- Counters never wrap. They are cleared at each threshold and do not count in IDLE.
- Reset mid-operation: all state returns to IDLE with every output 0 and no pulse. If the button is still held when reset_n deasserts, the block treats it as a new press after debounce.

## Timing
- Reset values: pressed = 0, short_pulse = 0, long_pulse = 0, repeat_pulse = 0; FSM in IDLE; all counters 0.
- All outputs are registered.
- Press latency: a clean raw edge to `pressed` takes 2 (sync) + DEBOUNCE_CYCLES cycles. Release latency is the same.
- long_pulse: high exactly LONG_CYCLES cycles after `pressed` rises, for one cycle.
- repeat_pulse: first pulse REPEAT_CYCLES cycles after long_pulse, then every REPEAT_CYCLES cycles.
- short_pulse: high the cycle after `pressed` falls, for one cycle.

## Structure
- Shared package clock_pkg holds:
  - the press-state enum (IDLE, SHORT, HELD)
  - board timing constants CLK_HZ = 50_000_000, DEBOUNCE_20MS, LONG_0P5S, REPEAT_0P2S
- One sub-module, btn_sync_debounce: synchroniser, polarity inversion and debounce counter, producing `pressed`.
- The FSM and the hold/repeat counters live in button_event_gen.

## Test plan
Parameters for all scenarios: DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8, ACTIVE_LOW=1.
- Reset: hold reset_n=0 with button_raw=0 (pressed) -> all outputs 0. After release, `pressed` rises 6 cycles later; FSM enters SHORT and no pulse occurs during reset.
- Short press: button_raw low for 12 cycles, then high -> exactly one short_pulse, 7 cycles after the rising edge; no long_pulse or repeat_pulse.
- Bounce: 3-cycle low glitches separated by 1-cycle highs -> `pressed` stays 0 and no pulses occur.
- Long press with repeat: low for 60 cycles -> long_pulse 20 cycles after `pressed` rises, repeat_pulse at +8 and +16 after it; no short_pulse on release.
- Boundary: release timed so `pressed` falls on the cycle cnt_hold reaches 19 -> short_pulse only.
- Reset mid-HELD: assert reset_n=0 between repeat pulses -> outputs 0 immediately; no further pulses until a new debounced press.
